// File: rtl/gpu_run_ctrl_if.sv
// rtl/gpu_run_ctrl_if.sv - host/core-side signal bundle for the GPU run controller
interface gpu_run_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 32
);
  logic                 START;
  logic                 ABORT;
  logic [NUM_CORES-1:0] HLT_REQ;
  logic [NUM_CORES-1:0] CORE_DONE;
  logic [NUM_CORES-1:0] CORE_RES;
  logic [NUM_CORES-1:0] CORE_HLT;
  logic [CNT_W-1:0]     CYCLES;
  logic [NUM_CORES-1:0] DONE_MASK;
  logic                 DONE;
  logic                 TIMEOUT;
  logic [2:0]           STATE;

  modport master (
    output START, ABORT, HLT_REQ, CORE_DONE,
    input  CORE_RES, CORE_HLT, CYCLES, DONE_MASK, DONE, TIMEOUT, STATE
  );

  modport slave (
    input  START, ABORT, HLT_REQ, CORE_DONE,
    output CORE_RES, CORE_HLT, CYCLES, DONE_MASK, DONE, TIMEOUT, STATE
  );
endinterface

// File: rtl/gpu_run_ctrl.sv
// rtl/gpu_run_ctrl.sv - reset/halt sequencing and cycle accounting for NUM_CORES GPU cores
module gpu_run_ctrl #(
  parameter int NUM_CORES  = 4,
  parameter int CNT_W      = 32,
  parameter int RESET_HOLD = 2,
  parameter int STAGGER    = 1,
  parameter int MAX_CYCLES = 100
) (
  input logic          CLK,
  input logic          RES,
  gpu_run_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HOLD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    FINISH  = 3'd4
  } state_t;

  // RELEASE lasts until the last core's slot; rel_q counts RELEASE cycles from 1
  localparam int REL_LAST = (NUM_CORES - 1) * STAGGER + 1;
  localparam int REL_W    = $clog2(REL_LAST + 1);
  localparam int HOLD_W   = $clog2(RESET_HOLD + 1);
  localparam logic [NUM_CORES-1:0] ALL_CORES = '1;
  localparam logic [CNT_W-1:0]     CYC_MAX   = '1;
  localparam logic [CNT_W-1:0]     CYC_LIMIT = CNT_W'(MAX_CYCLES);

  state_t               state_q, state_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [REL_W-1:0]     rel_q, rel_d, rel_nxt;
  logic                 rel_go;
  logic [NUM_CORES-1:0] core_res_q, core_res_d;
  logic [NUM_CORES-1:0] core_hlt_q, core_hlt_d;
  logic [NUM_CORES-1:0] mask_q, mask_d, mask_set;
  logic [CNT_W-1:0]     cyc_q, cyc_d, cyc_inc;
  logic                 done_q, done_d;
  logic                 tmo_q, tmo_d;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q    <= IDLE;
      hold_q     <= '0;
      rel_q      <= '0;
      core_res_q <= '1;
      core_hlt_q <= '0;
      mask_q     <= '0;
      cyc_q      <= '0;
      done_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      rel_q      <= rel_d;
      core_res_q <= core_res_d;
      core_hlt_q <= core_hlt_d;
      mask_q     <= mask_d;
      cyc_q      <= cyc_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    rel_d      = rel_q;
    rel_nxt    = rel_q;
    rel_go     = 1'b0;
    core_res_d = core_res_q;
    core_hlt_d = '0;
    mask_d     = mask_q;
    cyc_d      = cyc_q;
    done_d     = done_q;
    tmo_d      = tmo_q;
    cyc_inc    = (cyc_q == CYC_MAX) ? cyc_q : cyc_q + CNT_W'(1);
    // only cores already out of reset may report completion
    mask_set   = mask_q | (bus.CORE_DONE & ~core_res_q);

    if (bus.ABORT) begin
      state_d    = IDLE;
      hold_d     = '0;
      rel_d      = '0;
      core_res_d = '1;
      mask_d     = '0;
      cyc_d      = '0;
      done_d     = 1'b0;
      tmo_d      = 1'b0;
    end else begin
      case (state_q)
        IDLE, FINISH: begin
          if (state_q == IDLE) core_res_d = '1;
          else                 core_hlt_d = '1;
          if (bus.START) begin
            state_d    = HOLD;
            hold_d     = HOLD_W'(1);
            core_res_d = '1;
            core_hlt_d = '0;
            mask_d     = '0;
            cyc_d      = '0;
            done_d     = 1'b0;
            tmo_d      = 1'b0;
          end
        end
        HOLD: begin
          if (hold_q == HOLD_W'(RESET_HOLD)) begin
            state_d = RELEASE;
            rel_go  = 1'b1;
            rel_nxt = REL_W'(1);
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        RELEASE: begin
          mask_d = mask_set;
          if (rel_q == REL_W'(REL_LAST)) begin
            state_d = RUN;
          end else begin
            rel_go  = 1'b1;
            rel_nxt = rel_q + REL_W'(1);
          end
        end
        RUN: begin
          cyc_d      = cyc_inc;
          mask_d     = mask_set;
          core_hlt_d = bus.HLT_REQ;
          // completion outranks the cycle limit when both land together
          if (mask_set == ALL_CORES) begin
            state_d    = FINISH;
            done_d     = 1'b1;
            core_hlt_d = '1;
          end else if (MAX_CYCLES != 0 && cyc_inc == CYC_LIMIT) begin
            state_d    = FINISH;
            tmo_d      = 1'b1;
            core_hlt_d = '1;
          end
        end
        default: begin
          state_d    = IDLE;
          core_res_d = '1;
        end
      endcase
    end

    if (rel_go) begin
      rel_d = rel_nxt;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (rel_nxt >= REL_W'(i * STAGGER + 1)) core_res_d[i] = 1'b0;
      end
    end
  end

  assign bus.STATE     = state_q;
  assign bus.CORE_RES  = core_res_q;
  assign bus.CORE_HLT  = core_hlt_q;
  assign bus.CYCLES    = cyc_q;
  assign bus.DONE_MASK = mask_q;
  assign bus.DONE      = done_q;
  assign bus.TIMEOUT   = tmo_q;

endmodule

// File: tb/tb_gpu_run_ctrl.sv
// tb/tb_gpu_run_ctrl.sv - directed self-checking bench for gpu_run_ctrl
module tb_gpu_run_ctrl;

  logic CLK = 1'b0;
  logic RES;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 CLK = ~CLK;

  gpu_run_ctrl_if #(.NUM_CORES(4), .CNT_W(32)) bus_a ();
  gpu_run_ctrl_if #(.NUM_CORES(1), .CNT_W(32)) bus_b ();
  gpu_run_ctrl_if #(.NUM_CORES(4), .CNT_W(32)) bus_c ();

  gpu_run_ctrl #(.NUM_CORES(4), .CNT_W(32), .RESET_HOLD(2), .STAGGER(1), .MAX_CYCLES(100))
    dut_a (.CLK(CLK), .RES(RES), .bus(bus_a));
  gpu_run_ctrl #(.NUM_CORES(1), .CNT_W(32), .RESET_HOLD(2), .STAGGER(0), .MAX_CYCLES(0))
    dut_b (.CLK(CLK), .RES(RES), .bus(bus_b));
  gpu_run_ctrl #(.NUM_CORES(4), .CNT_W(32), .RESET_HOLD(2), .STAGGER(0), .MAX_CYCLES(100))
    dut_c (.CLK(CLK), .RES(RES), .bus(bus_c));

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_a_to_run(input string tag);
    bus_a.START = 1'b1;
    tick();
    bus_a.START = 1'b0;
    repeat (6) tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.CYCLES} !== {3'd3, 32'd0})
      $display("FAIL %s_enter_run: state=%0d cycles=%0d want state=3 cycles=0", tag, bus_a.STATE, bus_a.CYCLES);
    else n_pass++;
  endtask

  task automatic test_reset();
    RES = 1'b0;
    bus_a.START = 0; bus_a.ABORT = 0; bus_a.HLT_REQ = '0; bus_a.CORE_DONE = '0;
    bus_b.START = 0; bus_b.ABORT = 0; bus_b.HLT_REQ = '0; bus_b.CORE_DONE = '0;
    bus_c.START = 0; bus_c.ABORT = 0; bus_c.HLT_REQ = '0; bus_c.CORE_DONE = '0;
    repeat (2) tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.CORE_RES, bus_a.CORE_HLT, bus_a.DONE_MASK, bus_a.DONE, bus_a.TIMEOUT} !==
        {3'd0, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0})
      $display("FAIL reset_outputs: st=%0d res=%h hlt=%h mask=%h done=%b tmo=%b", bus_a.STATE,
               bus_a.CORE_RES, bus_a.CORE_HLT, bus_a.DONE_MASK, bus_a.DONE, bus_a.TIMEOUT);
    else n_pass++;
    n_checks++;
    if (bus_a.CYCLES !== 32'd0) $display("FAIL reset_cycles: got %0d want 0", bus_a.CYCLES);
    else n_pass++;
    RES = 1'b1;
    tick();
    n_checks++;
    if (bus_a.STATE !== 3'd0) $display("FAIL reset_idle_stays: got %0d want 0", bus_a.STATE);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [3:0] exp_res [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    bus_a.START = 1'b1;
    tick();
    bus_a.START = 1'b0;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({bus_a.STATE, bus_a.CORE_RES} !== {3'd1, 4'hF})
        $display("FAIL basic_hold%0d: st=%0d res=%h want st=1 res=f", k, bus_a.STATE, bus_a.CORE_RES);
      else n_pass++;
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({bus_a.STATE, bus_a.CORE_RES} !== {3'd2, exp_res[k]})
        $display("FAIL basic_release%0d: st=%0d res=%h want st=2 res=%h", k, bus_a.STATE, bus_a.CORE_RES, exp_res[k]);
      else n_pass++;
      tick();
    end
    n_checks++;
    if ({bus_a.STATE, bus_a.CORE_RES, bus_a.CORE_HLT} !== {3'd3, 4'h0, 4'h0})
      $display("FAIL basic_run_entry: st=%0d res=%h hlt=%h want 3/0/0", bus_a.STATE, bus_a.CORE_RES, bus_a.CORE_HLT);
    else n_pass++;
    repeat (9) tick();
    bus_a.CORE_DONE = 4'hF;
    tick();
    bus_a.CORE_DONE = 4'h0;
    n_checks++;
    if ({bus_a.STATE, bus_a.DONE, bus_a.TIMEOUT, bus_a.CORE_HLT, bus_a.CORE_RES, bus_a.DONE_MASK} !==
        {3'd4, 1'b1, 1'b0, 4'hF, 4'h0, 4'hF})
      $display("FAIL basic_finish: st=%0d done=%b tmo=%b hlt=%h res=%h mask=%h", bus_a.STATE,
               bus_a.DONE, bus_a.TIMEOUT, bus_a.CORE_HLT, bus_a.CORE_RES, bus_a.DONE_MASK);
    else n_pass++;
    n_checks++;
    if (bus_a.CYCLES !== 32'd10) $display("FAIL basic_cycles: got %0d want 10", bus_a.CYCLES);
    else n_pass++;
    repeat (3) tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.DONE, bus_a.CYCLES} !== {3'd4, 1'b1, 32'd10})
      $display("FAIL basic_finish_held: st=%0d done=%b cycles=%0d", bus_a.STATE, bus_a.DONE, bus_a.CYCLES);
    else n_pass++;
  endtask

  task automatic test_timeout();
    bus_a.START = 1'b1;
    tick();
    bus_a.START = 1'b0;
    n_checks++;
    if ({bus_a.STATE, bus_a.CYCLES, bus_a.DONE, bus_a.DONE_MASK, bus_a.CORE_RES, bus_a.CORE_HLT} !==
        {3'd1, 32'd0, 1'b0, 4'h0, 4'hF, 4'h0})
      $display("FAIL restart_clear: st=%0d cyc=%0d done=%b mask=%h res=%h hlt=%h", bus_a.STATE,
               bus_a.CYCLES, bus_a.DONE, bus_a.DONE_MASK, bus_a.CORE_RES, bus_a.CORE_HLT);
    else n_pass++;
    repeat (6) tick();
    repeat (99) tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.CYCLES} !== {3'd3, 32'd99})
      $display("FAIL timeout_pre: st=%0d cyc=%0d want 3/99", bus_a.STATE, bus_a.CYCLES);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.TIMEOUT, bus_a.DONE, bus_a.CYCLES, bus_a.CORE_HLT, bus_a.DONE_MASK} !==
        {3'd4, 1'b1, 1'b0, 32'd100, 4'hF, 4'h0})
      $display("FAIL timeout_finish: st=%0d tmo=%b done=%b cyc=%0d hlt=%h mask=%h", bus_a.STATE,
               bus_a.TIMEOUT, bus_a.DONE, bus_a.CYCLES, bus_a.CORE_HLT, bus_a.DONE_MASK);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    start_a_to_run("simul");
    repeat (50) tick();
    bus_a.CORE_DONE = 4'b0111;
    tick();
    bus_a.CORE_DONE = 4'b0000;
    n_checks++;
    if ({bus_a.STATE, bus_a.DONE_MASK, bus_a.CYCLES} !== {3'd3, 4'b0111, 32'd51})
      $display("FAIL simul_partial: st=%0d mask=%h cyc=%0d", bus_a.STATE, bus_a.DONE_MASK, bus_a.CYCLES);
    else n_pass++;
    repeat (48) tick();
    bus_a.CORE_DONE = 4'b1000;
    tick();
    bus_a.CORE_DONE = 4'b0000;
    n_checks++;
    if ({bus_a.STATE, bus_a.DONE, bus_a.TIMEOUT, bus_a.CYCLES, bus_a.DONE_MASK} !==
        {3'd4, 1'b1, 1'b0, 32'd100, 4'hF})
      $display("FAIL simul_done_wins: st=%0d done=%b tmo=%b cyc=%0d mask=%h", bus_a.STATE,
               bus_a.DONE, bus_a.TIMEOUT, bus_a.CYCLES, bus_a.DONE_MASK);
    else n_pass++;
  endtask

  task automatic test_halt_partial();
    start_a_to_run("halt");
    bus_a.HLT_REQ   = 4'b0101;
    bus_a.CORE_DONE = 4'b0101;
    n_checks++;
    if (bus_a.CORE_HLT !== 4'h0) $display("FAIL halt_latency: got %h want 0", bus_a.CORE_HLT);
    else n_pass++;
    tick();
    bus_a.CORE_DONE = 4'b0000;
    n_checks++;
    if ({bus_a.CORE_HLT, bus_a.DONE_MASK} !== {4'b0101, 4'b0101})
      $display("FAIL halt_applied: hlt=%h mask=%h want 5/5", bus_a.CORE_HLT, bus_a.DONE_MASK);
    else n_pass++;
    repeat (2) tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.DONE_MASK, bus_a.CORE_HLT, bus_a.CYCLES} !== {3'd3, 4'b0101, 4'b0101, 32'd3})
      $display("FAIL halt_sticky: st=%0d mask=%h hlt=%h cyc=%0d", bus_a.STATE, bus_a.DONE_MASK,
               bus_a.CORE_HLT, bus_a.CYCLES);
    else n_pass++;
    bus_a.HLT_REQ = 4'b0000;
    tick();
    n_checks++;
    if (bus_a.CORE_HLT !== 4'h0) $display("FAIL halt_drop: got %h want 0", bus_a.CORE_HLT);
    else n_pass++;
    tick();
  endtask

  task automatic test_abort();
    n_checks++;
    if ({bus_a.STATE, bus_a.CYCLES} !== {3'd3, 32'd5})
      $display("FAIL abort_pre: st=%0d cyc=%0d want 3/5", bus_a.STATE, bus_a.CYCLES);
    else n_pass++;
    bus_a.ABORT = 1'b1;
    bus_a.START = 1'b1;
    tick();
    bus_a.ABORT = 1'b0;
    bus_a.START = 1'b0;
    n_checks++;
    if ({bus_a.STATE, bus_a.CORE_RES, bus_a.CORE_HLT, bus_a.CYCLES, bus_a.DONE_MASK} !==
        {3'd0, 4'hF, 4'h0, 32'd0, 4'h0})
      $display("FAIL abort_idle: st=%0d res=%h hlt=%h cyc=%0d mask=%h", bus_a.STATE,
               bus_a.CORE_RES, bus_a.CORE_HLT, bus_a.CYCLES, bus_a.DONE_MASK);
    else n_pass++;
    tick();
    n_checks++;
    if (bus_a.STATE !== 3'd0) $display("FAIL abort_stays_idle: got %0d want 0", bus_a.STATE);
    else n_pass++;
  endtask

  task automatic test_reset_mid_release();
    bus_a.START = 1'b1;
    tick();
    bus_a.START = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.CORE_RES} !== {3'd2, 4'b1100})
      $display("FAIL midrel_pre: st=%0d res=%h want 2/c", bus_a.STATE, bus_a.CORE_RES);
    else n_pass++;
    #2 RES = 1'b0;
    #1;
    n_checks++;
    if ({bus_a.STATE, bus_a.CORE_RES, bus_a.CORE_HLT, bus_a.CYCLES} !== {3'd0, 4'hF, 4'h0, 32'd0})
      $display("FAIL midrel_async: st=%0d res=%h hlt=%h cyc=%0d", bus_a.STATE, bus_a.CORE_RES,
               bus_a.CORE_HLT, bus_a.CYCLES);
    else n_pass++;
    tick();
    RES = 1'b1;
    tick();
    n_checks++;
    if ({bus_a.STATE, bus_a.CORE_RES} !== {3'd0, 4'hF})
      $display("FAIL midrel_after: st=%0d res=%h want 0/f", bus_a.STATE, bus_a.CORE_RES);
    else n_pass++;
  endtask

  task automatic test_stagger0();
    bus_c.START = 1'b1;
    tick();
    bus_c.START = 1'b0;
    repeat (2) tick();
    n_checks++;
    if ({bus_c.STATE, bus_c.CORE_RES} !== {3'd2, 4'h0})
      $display("FAIL stagger0_release: st=%0d res=%h want 2/0", bus_c.STATE, bus_c.CORE_RES);
    else n_pass++;
    tick();
    n_checks++;
    if ({bus_c.STATE, bus_c.CYCLES} !== {3'd3, 32'd0})
      $display("FAIL stagger0_run: st=%0d cyc=%0d want 3/0", bus_c.STATE, bus_c.CYCLES);
    else n_pass++;
    bus_c.ABORT = 1'b1;
    tick();
    bus_c.ABORT = 1'b0;
  endtask

  task automatic test_corner_params();
    bus_b.START = 1'b1;
    tick();
    bus_b.START = 1'b0;
    tick();
    tick();
    n_checks++;
    if ({bus_b.STATE, bus_b.CORE_RES} !== {3'd2, 1'b0})
      $display("FAIL corner_release: st=%0d res=%b want 2/0", bus_b.STATE, bus_b.CORE_RES);
    else n_pass++;
    tick();
    repeat (1000) tick();
    n_checks++;
    if ({bus_b.STATE, bus_b.TIMEOUT, bus_b.CYCLES} !== {3'd3, 1'b0, 32'd1000})
      $display("FAIL corner_no_timeout: st=%0d tmo=%b cyc=%0d", bus_b.STATE, bus_b.TIMEOUT, bus_b.CYCLES);
    else n_pass++;
    bus_b.CORE_DONE = 1'b1;
    tick();
    bus_b.CORE_DONE = 1'b0;
    n_checks++;
    if ({bus_b.STATE, bus_b.DONE, bus_b.CYCLES, bus_b.CORE_HLT} !== {3'd4, 1'b1, 32'd1001, 1'b1})
      $display("FAIL corner_done: st=%0d done=%b cyc=%0d hlt=%b", bus_b.STATE, bus_b.DONE,
               bus_b.CYCLES, bus_b.CORE_HLT);
    else n_pass++;
    bus_b.START = 1'b1;
    tick();
    bus_b.START = 1'b0;
    n_checks++;
    if ({bus_b.STATE, bus_b.DONE, bus_b.CYCLES} !== {3'd1, 1'b0, 32'd0})
      $display("FAIL corner_restart: st=%0d done=%b cyc=%0d", bus_b.STATE, bus_b.DONE, bus_b.CYCLES);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_simultaneous();
    test_halt_partial();
    test_abort();
    test_reset_mid_release();
    test_stagger0();
    test_corner_params();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/gpu_run_ctrl.md
Name: gpu_run_ctrl

Overview:
- Parametrised run controller that sequences reset, halt and cycle accounting for NUM_CORES GPU instances.
- Replaces the fixed-delay reset release and hard 100-cycle stop used in simulation with a synthesizable controller.
- Adds staggered per-core reset release, per-core halt, completion tracking and a programmable timeout.
- Sits between the top-level clock/reset and the GPU cores; also drives run status to host/debug logic.

Parameters:
NUM_CORES, 4, number of GPU cores controlled (>=1)
CNT_W, 32, width of cycle counter
RESET_HOLD, 2, cycles all cores are held in reset after START (>=1)
STAGGER, 1, cycles between successive core reset releases (0 = simultaneous)
MAX_CYCLES, 100, RUN-cycle limit before timeout (0 = timeout disabled)

Ports:
CLK  input  1  clock, all state on rising edge
RES  input  1  asynchronous active-low reset
START  input  1  pulse: begin run (accepted in IDLE or FINISH only)
ABORT  input  1  pulse: return to IDLE from any state
HLT_REQ  input  NUM_CORES  per-core halt request
CORE_DONE  input  NUM_CORES  per-core completion indication
CORE_RES  output  NUM_CORES  per-core reset to GPU, active-high
CORE_HLT  output  NUM_CORES  per-core halt to GPU
CYCLES  output  CNT_W  RUN cycles elapsed, saturating
DONE_MASK  output  NUM_CORES  sticky record of cores that reported done
DONE  output  1  run completed, all cores done
TIMEOUT  output  1  run ended by cycle limit
STATE  output  3  encoded FSM state: IDLE=0, HOLD=1, RELEASE=2, RUN=3, FINISH=4

Behaviour:
- Reset (RES low, asynchronous):
  - STATE=IDLE, CORE_RES all 1, CORE_HLT all 0.
  - CYCLES=0, DONE_MASK=0, DONE=0, TIMEOUT=0.
- All outputs are registered.
- IDLE:
  - CORE_RES all 1.
  - START -> HOLD next cycle; clears CYCLES, DONE_MASK, DONE and TIMEOUT.
- HOLD:
  - CORE_RES all 1 for exactly RESET_HOLD cycles, then RELEASE.
- RELEASE:
  - Core i deasserts CORE_RES on the (i*STAGGER+1)-th cycle in RELEASE.
  - RUN is entered the cycle after core NUM_CORES-1 is released.
  - STAGGER=0: all cores release on the first RELEASE cycle, then RUN.
- RUN:
  - CYCLES increments by 1 per cycle and saturates at 2^CNT_W-1.
  - CORE_HLT[i] = HLT_REQ[i], registered (1-cycle latency).
  - DONE_MASK[i] is set when CORE_DONE[i]=1 and CORE_RES[i]=0; it stays set until the next START or ABORT.
  - CORE_DONE is also sampled during RELEASE for cores already released.
- RUN exit:
  - Next-state DONE_MASK all ones -> FINISH with DONE=1.
  - Else, if MAX_CYCLES!=0 and the incremented CYCLES == MAX_CYCLES -> FINISH with TIMEOUT=1.
  - If both conditions hold in the same cycle, DONE wins: DONE=1, TIMEOUT=0.
- FINISH:
  - CORE_HLT all 1; CORE_RES stays 0 so core state remains inspectable.
  - DONE, TIMEOUT, CYCLES and DONE_MASK are held.
  - START -> HOLD, clearing counters and flags.
- ABORT:
  - In any state except IDLE -> IDLE next cycle: CORE_RES all 1, CORE_HLT 0, flags and counters cleared.
  - ABORT has priority over START and over DONE/TIMEOUT detection in the same cycle.
- START is ignored in HOLD, RELEASE and RUN.
- Asynchronous reset mid-operation forces the reset values immediately, with no sequencing.
- HLT_REQ is ignored outside RUN: CORE_HLT is 0 in IDLE/HOLD/RELEASE and all 1 in FINISH.

Test Plan:
- Basic run (defaults; START at cycle 0, CORE_DONE=4'b1111 at RUN cycle 10)
  -> HOLD 2 cycles; CORE_RES steps 1111->1110->1100->1000->0000 on successive cycles; DONE=1, CYCLES=10, TIMEOUT=0.
- Timeout (CORE_DONE tied 0)
  -> FINISH after exactly 100 RUN cycles; TIMEOUT=1, CYCLES=100, CORE_HLT=4'b1111, DONE_MASK=0.
- Simultaneous (last CORE_DONE bit arrives on the cycle CYCLES reaches 100)
  -> DONE=1, TIMEOUT=0.
- Halt and partial done (HLT_REQ=4'b0101 in RUN; cores 0 and 2 done early)
  -> CORE_HLT=0101 one cycle later; DONE_MASK=0101 sticky after CORE_DONE drops; no FINISH.
- Abort/reset (ABORT at RUN cycle 5 together with START)
  -> IDLE next cycle, CORE_RES=1111, CYCLES=0.
  - Separately, RES low mid-RELEASE -> immediate reset values, no glitch on STATE.
- Restart and corner parameters (START in FINISH)
  -> clean second run with CYCLES restarting from 0.
  - Repeat with STAGGER=0, NUM_CORES=1, MAX_CYCLES=0: all cores release together; no timeout after 1000 cycles.
